bist_fail_logger: RTL and testbench

Diagnostic back end for the memory BIST: consumes the per-location compare stream produced during the BIST read phase, records every mismatching location with its pattern index and bit syndrome in a small FIFO, and lets a host or scan controller drain the log through a valid/ready port. Also keeps a saturating failure count, a sticky overflow flag and the first failing address. Sits beside the BIST controller/comparator and RAM, on the read-result side of the datapath.

---
 rtl/bist_pkg.sv | 16 +
 rtl/bist_log_fifo.sv | 57 +++++
 rtl/bist_fail_logger.sv | 112 +++++++++++
 tb/tb_bist_fail_logger.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the memory BIST diagnostic back end.
// Provides the default address/data widths, the pattern-index width and the
// default log entry layout that the FIFO uses when no other type is given.
package bist_pkg;

    localparam int SIZE_DEF   = 6;
    localparam int LENGTH_DEF = 8;
    localparam int PAT_W      = 3;

    typedef struct packed {
        logic [PAT_W-1:0]      pattern;
        logic [SIZE_DEF-1:0]   addr;
        logic [LENGTH_DEF-1:0] syndrome;
    } log_entry_t;

endpackage

// File: rtl/bist_log_fifo.sv
// Generic synchronous FIFO with a show-ahead head.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous flush (pointers back to zero)
//   push, push_data write an entry; caller guarantees !full || pop
//   pop             advance the head; caller guarantees !empty
//   head_data       entry at the head, valid whenever !empty
//   empty, full     occupancy flags
module bist_log_fifo
    import bist_pkg::*;
#(
    parameter type entry_t = log_entry_t,
    parameter int  DEPTH   = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head_data,
    output logic   empty,
    output logic   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // One extra pointer bit separates full from empty when the indices match.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    entry_t        mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is not reset; the head is only meaningful while !empty.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/bist_fail_logger.sv
// Memory BIST failure logger: records each mismatching compare
// {pattern, addr, expected^actual} in a small FIFO drained over valid/ready,
// and keeps a saturating failure count, sticky overflow and first-fail address.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   clear                    synchronous flush of log, counter and flags
//   cmp_valid/addr/pattern/expected/actual   compare stream from the BIST
//   log_valid/ready          drain handshake; log_* are zero when !log_valid
//   log_addr/pattern/syndrome head entry fields
//   fail_count               mismatches since clear, saturating
//   overflow                 sticky: a mismatch was dropped on a full log
//   first_valid/first_addr   first mismatch since clear
//   log_full                 FIFO holds DEPTH entries
module bist_fail_logger
    import bist_pkg::*;
#(
    parameter int size   = SIZE_DEF,
    parameter int length = LENGTH_DEF,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cmp_valid,
    input  logic [size-1:0]   cmp_addr,
    input  logic [PAT_W-1:0]  cmp_pattern,
    input  logic [length-1:0] cmp_expected,
    input  logic [length-1:0] cmp_actual,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [size-1:0]   log_addr,
    output logic [PAT_W-1:0]  log_pattern,
    output logic [length-1:0] log_syndrome,
    output logic [CNT_W-1:0]  fail_count,
    output logic              overflow,
    output logic              first_valid,
    output logic [size-1:0]   first_addr,
    output logic              log_full
);

    // Entry layout follows this instance's widths rather than the package defaults.
    typedef struct packed {
        logic [PAT_W-1:0]  pattern;
        logic [size-1:0]   addr;
        logic [length-1:0] syndrome;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t push_entry;
    entry_t head;
    logic   empty;
    logic   mismatch;
    logic   pop;
    logic   push;
    logic   drop;

    assign mismatch = cmp_valid && (cmp_expected != cmp_actual);

    // log_valid comes straight from registered pointers, so it never
    // depends on log_ready. Clear overrides both push and pop.
    assign log_valid = !empty;
    assign pop       = log_valid && log_ready && !clear;
    assign push      = mismatch && !clear && (!log_full || pop);
    assign drop      = mismatch && !clear && log_full && !pop;

    assign push_entry.pattern  = cmp_pattern;
    assign push_entry.addr     = cmp_addr;
    assign push_entry.syndrome = cmp_expected ^ cmp_actual;

    bist_log_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .empty     (empty),
        .full      (log_full)
    );

    assign log_addr     = log_valid ? head.addr     : '0;
    assign log_pattern  = log_valid ? head.pattern  : '0;
    assign log_syndrome = log_valid ? head.syndrome : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_count  <= '0;
            overflow    <= 1'b0;
            first_valid <= 1'b0;
            first_addr  <= '0;
        end else if (clear) begin
            fail_count  <= '0;
            overflow    <= 1'b0;
            first_valid <= 1'b0;
            first_addr  <= '0;
        end else begin
            if (mismatch && fail_count != CNT_MAX) fail_count <= fail_count + CNT_W'(1);
            if (drop) overflow <= 1'b1;
            if (mismatch && !first_valid) begin
                first_valid <= 1'b1;
                first_addr  <= cmp_addr;
            end
        end
    end

endmodule

// File: tb/tb_bist_fail_logger.sv
module tb_bist_fail_logger;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       cmp_valid = 1'b0;
    logic [5:0] cmp_addr = '0;
    logic [2:0] cmp_pattern = '0;
    logic [7:0] cmp_expected = '0;
    logic [7:0] cmp_actual = '0;
    logic       log_ready = 1'b0;

    logic        log_valid, overflow, first_valid, log_full;
    logic [5:0]  log_addr, first_addr;
    logic [2:0]  log_pattern;
    logic [7:0]  log_syndrome;
    logic [15:0] fail_count;

    logic        v4, ov4, fv4, full4;
    logic [5:0]  addr4, fa4;
    logic [2:0]  pat4;
    logic [7:0]  syn4;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    bist_fail_logger #(.size(6), .length(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clear(clear), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
        .cmp_pattern(cmp_pattern), .cmp_expected(cmp_expected), .cmp_actual(cmp_actual),
        .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
        .log_pattern(log_pattern), .log_syndrome(log_syndrome), .fail_count(fail_count),
        .overflow(overflow), .first_valid(first_valid), .first_addr(first_addr),
        .log_full(log_full)
    );

    bist_fail_logger #(.size(6), .length(8), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
        .cmp_pattern(cmp_pattern), .cmp_expected(cmp_expected), .cmp_actual(cmp_actual),
        .log_valid(v4), .log_ready(log_ready), .log_addr(addr4),
        .log_pattern(pat4), .log_syndrome(syn4), .fail_count(cnt4),
        .overflow(ov4), .first_valid(fv4), .first_addr(fa4),
        .log_full(full4)
    );

    // Reference model: the log is a plain queue of {pattern, addr, syndrome}.
    typedef struct packed {
        logic [2:0] pat;
        logic [5:0] addr;
        logic [7:0] syn;
    } m_ent_t;

    m_ent_t     m_q[$];
    int         m_cnt;
    bit         m_ov;
    bit         m_fv;
    logic [5:0] m_fa;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt = 0;
        m_ov  = 0;
        m_fv  = 0;
        m_fa  = '0;
    endtask

    task automatic model_update(input bit v, input logic [5:0] a, input logic [2:0] p,
                                input logic [7:0] e, input logic [7:0] d,
                                input bit rdy, input bit clr);
        bit mm;
        if (clr) begin
            model_reset();
            return;
        end
        mm = v && (e != d);
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (mm) begin
            if (m_q.size() < DEPTH) m_q.push_back('{pat: p, addr: a, syn: e ^ d});
            else m_ov = 1;
            m_cnt++;
            if (!m_fv) begin
                m_fv = 1;
                m_fa = a;
            end
        end
    endtask

    task automatic check_all(input string tag);
        m_ent_t h;
        bit     mv;
        int     c16, c4;
        mv  = (m_q.size() > 0);
        h   = mv ? m_q[0] : '0;
        c16 = (m_cnt > 65535) ? 65535 : m_cnt;
        c4  = (m_cnt > 15) ? 15 : m_cnt;
        chk({tag, ".log_valid"},    32'(log_valid),    32'(mv));
        chk({tag, ".log_addr"},     32'(log_addr),     32'(h.addr));
        chk({tag, ".log_pattern"},  32'(log_pattern),  32'(h.pat));
        chk({tag, ".log_syndrome"}, 32'(log_syndrome), 32'(h.syn));
        chk({tag, ".fail_count"},   32'(fail_count),   32'(c16));
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ov));
        chk({tag, ".first_valid"},  32'(first_valid),  32'(m_fv));
        chk({tag, ".first_addr"},   32'(first_addr),   32'(m_fa));
        chk({tag, ".log_full"},     32'(log_full),     32'(m_q.size() == DEPTH));
        chk({tag, ".c4.fail_count"}, 32'(cnt4), 32'(c4));
        chk({tag, ".c4.log_valid"},  32'(v4),   32'(mv));
        chk({tag, ".c4.log_addr"},   32'(addr4), 32'(h.addr));
        chk({tag, ".c4.log_pattern"}, 32'(pat4), 32'(h.pat));
        chk({tag, ".c4.log_syndrome"}, 32'(syn4), 32'(h.syn));
        chk({tag, ".c4.overflow"},   32'(ov4),  32'(m_ov));
        chk({tag, ".c4.first"},      32'({fv4, fa4}), 32'({m_fv, m_fa}));
        chk({tag, ".c4.log_full"},   32'(full4), 32'(m_q.size() == DEPTH));
    endtask

    // Called just after an active edge; applies one cycle of stimulus and checks.
    task automatic step(input string tag, input bit v, input logic [5:0] a,
                        input logic [2:0] p, input logic [7:0] e, input logic [7:0] d,
                        input bit rdy, input bit clr);
        cmp_valid    = v;
        cmp_addr     = a;
        cmp_pattern  = p;
        cmp_expected = e;
        cmp_actual   = d;
        log_ready    = rdy;
        clear        = clr;
        model_update(v, a, p, e, d, rdy, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input bit rdy);
        step(tag, 1'b0, 6'd0, 3'd0, 8'h00, 8'h00, rdy, 1'b0);
    endtask

    typedef struct {
        bit         v;
        logic [5:0] a;
        logic [2:0] p;
        logic [7:0] e;
        logic [7:0] d;
        bit         rdy;
        bit         clr;
        bit         x_valid;
        logic [5:0] x_addr;
        logic [2:0] x_pat;
        logic [7:0] x_syn;
        int         x_cnt;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [5:0] exp_addr[8];
        logic [7:0] e, d;

        vt[0] = '{1, 6'd5,  3'd2, 8'h55, 8'h57, 0, 0, 1, 6'd5,  3'd2, 8'h02, 1};
        vt[1] = '{0, 6'd0,  3'd0, 8'h00, 8'h00, 1, 0, 0, 6'd0,  3'd0, 8'h00, 1};
        vt[2] = '{1, 6'd9,  3'd7, 8'hFF, 8'h00, 1, 0, 1, 6'd9,  3'd7, 8'hFF, 2};
        vt[3] = '{1, 6'd3,  3'd1, 8'h3C, 8'h3C, 0, 0, 1, 6'd9,  3'd7, 8'hFF, 2};
        vt[4] = '{1, 6'd12, 3'd1, 8'h0F, 8'h0E, 1, 0, 1, 6'd12, 3'd1, 8'h01, 3};
        vt[5] = '{1, 6'd20, 3'd4, 8'hF0, 8'h00, 1, 1, 0, 6'd0,  3'd0, 8'h00, 0};

        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 64; i++)
            step("match", 1'b1, 6'(i), 3'(i), 8'hAA, 8'hAA, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            step("tbl", vt[i].v, vt[i].a, vt[i].p, vt[i].e, vt[i].d, vt[i].rdy, vt[i].clr);
            chk($sformatf("tbl%0d.valid", i), 32'(log_valid),    32'(vt[i].x_valid));
            chk($sformatf("tbl%0d.addr", i),  32'(log_addr),     32'(vt[i].x_addr));
            chk($sformatf("tbl%0d.pat", i),   32'(log_pattern),  32'(vt[i].x_pat));
            chk($sformatf("tbl%0d.syn", i),   32'(log_syndrome), 32'(vt[i].x_syn));
            chk($sformatf("tbl%0d.cnt", i),   32'(fail_count),   32'(vt[i].x_cnt));
        end

        // Ten mismatches into an 8-deep log with no draining.
        for (int i = 0; i < 10; i++) begin
            step("fill10", 1'b1, 6'(i), 3'd1, 8'h00, 8'h81, 1'b0, 1'b0);
            if (i == 7) chk("full_after8", 32'(log_full), 32'd1);
        end
        chk("ovf_after10",  32'(overflow),   32'd1);
        chk("cnt_after10",  32'(fail_count), 32'd10);
        chk("first_addr10", 32'(first_addr), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("drain10_order", 32'(log_addr), 32'(i));
            idle("drain10", 1'b1);
        end

        // Full log with mismatch and pop in the same cycle.
        step("clr", 1'b0, 6'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            step("fill8", 1'b1, 6'(i), 3'd3, 8'h11, 8'h10, 1'b0, 1'b0);
        step("full_push_pop", 1'b1, 6'd63, 3'd6, 8'hA5, 8'h5A, 1'b1, 1'b0);
        chk("fpp_overflow", 32'(overflow), 32'd0);
        chk("fpp_full",     32'(log_full), 32'd1);
        for (int i = 0; i < 7; i++) exp_addr[i] = 6'(i + 1);
        exp_addr[7] = 6'd63;
        for (int i = 0; i < 8; i++) begin
            chk("fpp_drain_order", 32'(log_addr), 32'(exp_addr[i]));
            idle("fpp_drain", 1'b1);
        end
        chk("fpp_empty", 32'(log_valid), 32'd0);

        // Saturation of the narrow counter, then clear with a colliding mismatch.
        step("clr", 1'b0, 6'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            step("sat", 1'b1, 6'(i + 30), 3'd5, 8'hC3, 8'hC7, 1'(i % 3 == 0), 1'b0);
        chk("sat_cnt4",  32'(cnt4),       32'd15);
        chk("sat_cnt16", 32'(fail_count), 32'd20);
        step("clr_mm", 1'b1, 6'd44, 3'd2, 8'h01, 8'h02, 1'b1, 1'b1);
        chk("clr_cnt4",   32'(cnt4),        32'd0);
        chk("clr_valid",  32'(log_valid),   32'd0);
        chk("clr_first",  32'(first_valid), 32'd0);
        chk("clr_ovf",    32'(overflow),    32'd0);
        idle("clr_after", 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            e = 8'($urandom);
            d = ($urandom_range(0, 1) == 1) ? e : (e ^ 8'($urandom_range(1, 255)));
            step("rand", $urandom_range(0, 9) < 7, 6'($urandom), 3'($urandom), e, d,
                 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
        end

        // Asynchronous reset while entries are held and the host is draining.
        step("clr", 1'b0, 6'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("pre_rst", 1'b1, 6'(i + 40), 3'd7, 8'h00, 8'hFF, 1'b0, 1'b0);
        step("pre_rst_rdy", 1'b0, 6'd0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        log_ready = 1'b0;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_release");
        step("post_rst", 1'b1, 6'd17, 3'd3, 8'h0F, 8'hF0, 1'b0, 1'b0);
        chk("post_rst_addr", 32'(log_addr),     32'd17);
        chk("post_rst_syn",  32'(log_syndrome), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
